// File: rtl/eth_cmd_pkg.sv
// eth_cmd_pkg
// Shared definitions for the Ethernet command executor:
//   - host command codes and result codes
//   - one-hot FSM state encoding
//   - names for the configuration register slots
//   - addr_in_range(): true when a register address fits in the register file
package eth_cmd_pkg;

    // Host command codes
    localparam logic [15:0] CMD_WRITE_REG = 16'h0001;
    localparam logic [15:0] CMD_READ_REG  = 16'h0002;
    localparam logic [15:0] CMD_START_ACQ = 16'h0003;
    localparam logic [15:0] CMD_STOP_ACQ  = 16'h0004;

    // Result codes; bit 15 set marks an error
    localparam logic [15:0] RES_OK       = 16'h0000;
    localparam logic [15:0] RES_UNKNOWN  = 16'h8001;
    localparam logic [15:0] RES_BAD_ADDR = 16'h8002;
    localparam logic [15:0] RES_BUSY     = 16'h8003;
    localparam logic [15:0] RES_TIMEOUT  = 16'h8004;

    // One-hot executor states
    typedef enum logic [4:0] {
        S_IDLE     = 5'b00001,
        S_DECODE   = 5'b00010,
        S_EXEC     = 5'b00100,
        S_WAIT_ACK = 5'b01000,
        S_FINISH   = 5'b10000
    } state_e;

    // Configuration register slots feeding pulser / ADC control
    localparam int REG_GAIN    = 0;
    localparam int REG_PRF     = 1;
    localparam int REG_PULSE_W = 2;
    localparam int REG_ADC_DLY = 3;

    // An 8-bit host address is valid only when every bit above addr_w is 0
    function automatic logic addr_in_range(input logic [7:0] addr,
                                           input int unsigned addr_w);
        return (addr >> addr_w) == 8'd0;
    endfunction

endpackage

// File: rtl/cmd_edge_sync.sv
// cmd_edge_sync
// Rising-edge detector with a registered output.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   i_sig   : level input (command strobe)
//   o_rise  : one-cycle pulse, the cycle after i_sig is first sampled high
module cmd_edge_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic sig_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sig_q  <= 1'b0;
            o_rise <= 1'b0;
        end else begin
            sig_q  <= i_sig;
            o_rise <= i_sig & ~sig_q;
        end
    end

endmodule

// File: rtl/eth_cmd_exec.sv
// eth_cmd_exec
// Executes decoded host commands from the Ethernet session block: register
// writes/reads and acquisition start/stop. Reports completion back to the
// session through a level handshake.
//
// Handshake with the session: a rising edge of i_cmd_come while the
// executor is idle starts a command (i_cmd/i_param must be stable on that
// edge). o_cmd_finish drops on accept and stays low for at least MIN_LOW
// cycles; its rise means "done", and o_finish_code is already valid on the
// rise cycle and holds until the next accepted command. Edges that arrive
// while a command is executing are discarded.
//
// Ports:
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_cmd_come          : command strobe (rising edge = new command)
//   i_cmd, i_param      : command code and parameter
//   o_cmd_finish        : 1 = idle/done, 0 = executing
//   o_finish_code       : result code
//   o_regs              : NREG x 15-bit register file, reg k at [15k+14:15k]
//   o_acq_start/stop    : one-cycle acquisition control pulses
//   o_acq_frames        : frame count latched on start (0 = continuous)
//   i_acq_busy          : capture engine running
//   o_dbg_state         : current one-hot FSM state
//
// Build option: define ETH_CMD_WDOG_EN to bound the wait for i_acq_busy
// after a start by ACK_TIMEOUT cycles (result 0x8004 on expiry). Without it
// the executor waits for the acknowledge indefinitely.
module eth_cmd_exec
    import eth_cmd_pkg::*;
#(
    parameter int NREG        = 8,
    parameter int ADDR_W      = 3,
    parameter int ACK_TIMEOUT = 1000000,
    parameter int MIN_LOW     = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cmd_come,
    input  logic [15:0]          i_cmd,
    input  logic [31:0]          i_param,
    output logic                 o_cmd_finish,
    output logic [15:0]          o_finish_code,
    output logic [NREG*15-1:0]   o_regs,
    output logic                 o_acq_start,
    output logic                 o_acq_stop,
    output logic [31:0]          o_acq_frames,
    input  logic                 i_acq_busy,
    output logic [4:0]           o_dbg_state
);

    localparam int LOW_W = $clog2(MIN_LOW) + 1;
    localparam logic [LOW_W-1:0] LOW_LAST = LOW_W'(MIN_LOW - 1);

`ifdef ETH_CMD_WDOG_EN
    localparam int TMO_W = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    state_e             state;
    logic               cmd_rise;
    logic [15:0]        cmd_q;
    logic [31:0]        param_q;
    logic               err_q;
    logic [LOW_W-1:0]   low_cnt;
    logic [14:0]        regs [NREG];

    logic [ADDR_W-1:0]  reg_idx;
    logic               addr_ok;
    logic [15:0]        dec_code;

    cmd_edge_sync u_come_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_sig   (i_cmd_come),
        .o_rise  (cmd_rise)
    );

    assign reg_idx     = param_q[24 +: ADDR_W];
    assign addr_ok     = addr_in_range(param_q[31:24], ADDR_W);
    assign o_dbg_state = state;

    // Result selected in DECODE. A READ result never has bit 15 set, so
    // bit 15 of the code doubles as the error flag for EXEC.
    always_comb begin
        dec_code = RES_OK;
        case (cmd_q)
            CMD_WRITE_REG: if (!addr_ok) dec_code = RES_BAD_ADDR;
            CMD_READ_REG:  dec_code = addr_ok ? {1'b0, regs[reg_idx]} : RES_BAD_ADDR;
            CMD_START_ACQ: if (i_acq_busy) dec_code = RES_BUSY;
            CMD_STOP_ACQ:  dec_code = RES_OK;
            default:       dec_code = RES_UNKNOWN;
        endcase
    end

    always_comb begin
        o_regs = '0;
        for (int k = 0; k < NREG; k++) begin
            o_regs[15*k +: 15] = regs[k];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            cmd_q         <= '0;
            param_q       <= '0;
            err_q         <= 1'b0;
            low_cnt       <= '0;
            o_cmd_finish  <= 1'b1;
            o_finish_code <= RES_OK;
            o_acq_start   <= 1'b0;
            o_acq_stop    <= 1'b0;
            o_acq_frames  <= '0;
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= '0;
            end
`ifdef ETH_CMD_WDOG_EN
            tmo_cnt       <= '0;
`endif
        end else begin
            o_acq_start <= 1'b0;
            o_acq_stop  <= 1'b0;

            // Low-time counter runs while busy and saturates at its target
            if (state != S_IDLE && low_cnt != LOW_LAST) begin
                low_cnt <= low_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (cmd_rise) begin
                        cmd_q        <= i_cmd;
                        param_q      <= i_param;
                        o_cmd_finish <= 1'b0;
                        low_cnt      <= '0;
                        state        <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    o_finish_code <= dec_code;
                    err_q         <= dec_code[15];
                    // Pulses are launched here so they are high during EXEC
                    if (!dec_code[15]) begin
                        if (cmd_q == CMD_START_ACQ) begin
                            o_acq_start  <= 1'b1;
                            o_acq_frames <= param_q;
                        end
                        if (cmd_q == CMD_STOP_ACQ) begin
                            o_acq_stop <= 1'b1;
                        end
                    end
                    state <= S_EXEC;
                end

                S_EXEC: begin
                    if (!err_q && cmd_q == CMD_WRITE_REG) begin
                        regs[reg_idx] <= param_q[14:0];
                    end
`ifdef ETH_CMD_WDOG_EN
                    tmo_cnt <= '0;
`endif
                    if (!err_q && cmd_q == CMD_START_ACQ) begin
                        state <= S_WAIT_ACK;
                    end else begin
                        state <= S_FINISH;
                    end
                end

                S_WAIT_ACK: begin
                    if (i_acq_busy) begin
                        o_finish_code <= RES_OK;
                        state         <= S_FINISH;
                    end
`ifdef ETH_CMD_WDOG_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        o_finish_code <= RES_TIMEOUT;
                        state         <= S_FINISH;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end

                S_FINISH: begin
                    if (low_cnt == LOW_LAST) begin
                        o_cmd_finish <= 1'b1;
                        state        <= S_IDLE;
                    end
                end

                default: begin
                    o_cmd_finish <= 1'b1;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_cmd_exec.sv
module tb_eth_cmd_exec;
    import eth_cmd_pkg::*;

    localparam int NREG = 8;

    logic                 i_clk;
    logic                 i_rst_n;
    logic                 i_cmd_come;
    logic [15:0]          i_cmd;
    logic [31:0]          i_param;
    logic                 o_cmd_finish;
    logic [15:0]          o_finish_code;
    logic [NREG*15-1:0]   o_regs;
    logic                 o_acq_start;
    logic                 o_acq_stop;
    logic [31:0]          o_acq_frames;
    logic                 i_acq_busy;
    logic [4:0]           o_dbg_state;

    int n_checks;
    int n_err;
    logic [14:0] model_regs [NREG];
    logic [31:0] exp_frames;

    eth_cmd_exec #(
        .NREG        (NREG),
        .ADDR_W      (3),
        .ACK_TIMEOUT (20),
        .MIN_LOW     (4)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_cmd_come    (i_cmd_come),
        .i_cmd         (i_cmd),
        .i_param       (i_param),
        .o_cmd_finish  (o_cmd_finish),
        .o_finish_code (o_finish_code),
        .o_regs        (o_regs),
        .o_acq_start   (o_acq_start),
        .o_acq_stop    (o_acq_stop),
        .o_acq_frames  (o_acq_frames),
        .i_acq_busy    (i_acq_busy),
        .o_dbg_state   (o_dbg_state)
    );

    // clock
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] cmd;
        logic [31:0] param;
        bit          pre_busy;
        int          busy_delay;
        logic [15:0] exp_code;
        int          exp_low;
        int          exp_start;
        int          exp_stop;
        int          exp_wait;
        bit          wr;
        int          wr_idx;
        logic [14:0] wr_val;
        logic [31:0] exp_frames;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NREG*15-1:0] flat_model();
        logic [NREG*15-1:0] f;
        f = '0;
        for (int k = 0; k < NREG; k++) f[15*k +: 15] = model_regs[k];
        return f;
    endfunction

    // Issue one command and watch it to completion (bounded).
    task automatic run_cmd(input logic [15:0] cmd, input logic [31:0] param,
                           input int busy_delay,
                           output logic [15:0] code, output int low,
                           output int starts, output int stops,
                           output int waits, output bit done);
        int since_start;
        bit seen_low;
        code = '0; low = 0; starts = 0; stops = 0; waits = 0; done = 1'b0;
        since_start = -1; seen_low = 1'b0;
        @(negedge i_clk);
        i_cmd = cmd; i_param = param; i_cmd_come = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge i_clk);
            if (i == 3) i_cmd_come = 1'b0;
            if (o_acq_start) begin
                starts++;
                since_start = 0;
            end else if (since_start >= 0) begin
                since_start++;
            end
            if (o_acq_stop) stops++;
            if (o_dbg_state == S_WAIT_ACK) waits++;
            if (!o_cmd_finish) begin
                low++;
                seen_low = 1'b1;
            end else if (seen_low) begin
                done = 1'b1;
                code = o_finish_code;
            end
            if (busy_delay >= 0 && since_start == busy_delay) i_acq_busy = 1'b1;
        end
        i_cmd_come = 1'b0;
    endtask

    logic [15:0] r_code;
    int r_low, r_starts, r_stops, r_waits;
    bit r_done;
    int rises;
    logic prev_fin;
    bit reached;

    initial begin
        n_checks = 0;
        n_err = 0;
        exp_frames = '0;
        for (int k = 0; k < NREG; k++) model_regs[k] = '0;

        vecs[0]  = '{16'h0001, 32'h0200_1234, 1'b0, -1, 16'h0000, 4, 0, 0, 0, 1'b1, 2, 15'h1234, 32'd0};
        vecs[1]  = '{16'h0002, 32'h0200_0000, 1'b0, -1, 16'h1234, 4, 0, 0, 0, 1'b0, 0, 15'h0000, 32'd0};
        vecs[2]  = '{16'h0002, 32'h0900_0000, 1'b0, -1, 16'h8002, 4, 0, 0, 0, 1'b0, 0, 15'h0000, 32'd0};
        vecs[3]  = '{16'h0001, 32'h0900_5555, 1'b0, -1, 16'h8002, 4, 0, 0, 0, 1'b0, 0, 15'h0000, 32'd0};
        vecs[4]  = '{16'h0001, 32'h0700_FFFF, 1'b0, -1, 16'h0000, 4, 0, 0, 0, 1'b1, 7, 15'h7FFF, 32'd0};
        vecs[5]  = '{16'h0002, 32'h0700_0000, 1'b0, -1, 16'h7FFF, 4, 0, 0, 0, 1'b0, 0, 15'h0000, 32'd0};
        vecs[6]  = '{16'h0001, 32'h0800_1111, 1'b0, -1, 16'h8002, 4, 0, 0, 0, 1'b0, 0, 15'h0000, 32'd0};
        vecs[7]  = '{16'h00FF, 32'h0000_0000, 1'b0, -1, 16'h8001, 4, 0, 0, 0, 1'b0, 0, 15'h0000, 32'd0};
        vecs[8]  = '{16'h0000, 32'h0100_0001, 1'b0, -1, 16'h8001, 4, 0, 0, 0, 1'b0, 0, 15'h0000, 32'd0};
        vecs[9]  = '{16'h0004, 32'h0000_0000, 1'b0, -1, 16'h0000, 4, 0, 1, 0, 1'b0, 0, 15'h0000, 32'd0};
        vecs[10] = '{16'h0004, 32'h0000_0000, 1'b1, -1, 16'h0000, 4, 0, 1, 0, 1'b0, 0, 15'h0000, 32'd0};
        vecs[11] = '{16'h0003, 32'h0000_0063, 1'b1, -1, 16'h8003, 4, 0, 0, 0, 1'b0, 0, 15'h0000, 32'd0};
        vecs[12] = '{16'h0003, 32'h0000_000A, 1'b0,  5, 16'h0000, 8, 1, 0, 5, 1'b0, 0, 15'h0000, 32'd10};
        vecs[13] = '{16'h0002, 32'h0000_0000, 1'b0, -1, 16'h0000, 4, 0, 0, 0, 1'b0, 0, 15'h0000, 32'd10};

        // reset
        i_rst_n = 1'b0; i_cmd_come = 1'b0; i_cmd = '0; i_param = '0; i_acq_busy = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rst_finish", 128'(o_cmd_finish), 128'(1'b1));
        check("rst_code",   128'(o_finish_code), 128'(16'h0000));
        check("rst_regs",   128'(o_regs), 128'(0));
        check("rst_start",  128'(o_acq_start), 128'(1'b0));
        check("rst_stop",   128'(o_acq_stop), 128'(1'b0));
        check("rst_frames", 128'(o_acq_frames), 128'(0));
        check("rst_state",  128'(o_dbg_state), 128'(5'b00001));

        // table-driven vectors
        for (int v = 0; v < 14; v++) begin
            i_acq_busy = vecs[v].pre_busy;
            run_cmd(vecs[v].cmd, vecs[v].param, vecs[v].busy_delay,
                    r_code, r_low, r_starts, r_stops, r_waits, r_done);
            check($sformatf("v%0d_done", v), 128'(r_done), 128'(1'b1));
            check($sformatf("v%0d_code", v), 128'(r_code), 128'(vecs[v].exp_code));
            check($sformatf("v%0d_low", v), 128'(r_low), 128'(vecs[v].exp_low));
            check($sformatf("v%0d_starts", v), 128'(r_starts), 128'(vecs[v].exp_start));
            check($sformatf("v%0d_stops", v), 128'(r_stops), 128'(vecs[v].exp_stop));
            check($sformatf("v%0d_waits", v), 128'(r_waits), 128'(vecs[v].exp_wait));
            if (vecs[v].wr) model_regs[vecs[v].wr_idx] = vecs[v].wr_val;
            check($sformatf("v%0d_regs", v), 128'(o_regs), 128'(flat_model()));
            check($sformatf("v%0d_frames", v), 128'(o_acq_frames), 128'(vecs[v].exp_frames));
            repeat (3) @(negedge i_clk);
            check($sformatf("v%0d_code_hold", v), 128'(o_finish_code), 128'(vecs[v].exp_code));
            i_acq_busy = 1'b0;
        end
        exp_frames = 32'd10;

        // second strobe edge while a command is executing is dropped
        @(negedge i_clk);
        i_cmd = 16'h0001; i_param = 32'h0300_0ABC; i_cmd_come = 1'b1;
        rises = 0; prev_fin = o_cmd_finish;
        for (int i = 0; i < 30; i++) begin
            @(negedge i_clk);
            if (i == 1) i_cmd_come = 1'b0;
            if (i == 2) begin
                i_param = 32'h0400_0555;
                i_cmd_come = 1'b1;
            end
            if (i == 6) i_cmd_come = 1'b0;
            if (o_cmd_finish && !prev_fin) rises++;
            prev_fin = o_cmd_finish;
        end
        model_regs[3] = 15'h0ABC;
        check("dbl_rises", 128'(rises), 128'(1));
        check("dbl_regs",  128'(o_regs), 128'(flat_model()));
        check("dbl_code",  128'(o_finish_code), 128'(16'h0000));

`ifdef ETH_CMD_WDOG_EN
        // acknowledge never arrives: timeout after 20 cycles in WAIT_ACK
        run_cmd(16'h0003, 32'h0000_0003, -1, r_code, r_low, r_starts, r_stops, r_waits, r_done);
        exp_frames = 32'd3;
        check("wdog_done",   128'(r_done), 128'(1'b1));
        check("wdog_code",   128'(r_code), 128'(16'h8004));
        check("wdog_waits",  128'(r_waits), 128'(20));
        check("wdog_low",    128'(r_low), 128'(23));
        check("wdog_starts", 128'(r_starts), 128'(1));
        check("wdog_frames", 128'(o_acq_frames), 128'(exp_frames));
`endif

        // leave a nonzero code behind, then reset in the middle of WAIT_ACK
        run_cmd(16'h0002, 32'h0900_0000, -1, r_code, r_low, r_starts, r_stops, r_waits, r_done);
        check("pre_rst_code", 128'(r_code), 128'(16'h8002));
        @(negedge i_clk);
        i_cmd = 16'h0003; i_param = 32'h0000_0007; i_cmd_come = 1'b1;
        reached = 1'b0; r_starts = 0;
        for (int i = 0; i < 20 && !reached; i++) begin
            @(negedge i_clk);
            if (o_acq_start) r_starts++;
            if (o_dbg_state == S_WAIT_ACK) reached = 1'b1;
        end
        check("rst_mid_reached", 128'(reached), 128'(1'b1));
        check("rst_mid_starts",  128'(r_starts), 128'(1));
        check("rst_mid_frames",  128'(o_acq_frames), 128'(32'd7));
        @(negedge i_clk);
        #1 i_rst_n = 1'b0;
        #1;
        check("rst_mid_finish", 128'(o_cmd_finish), 128'(1'b1));
        check("rst_mid_code",   128'(o_finish_code), 128'(16'h0000));
        check("rst_mid_regs",   128'(o_regs), 128'(0));
        check("rst_mid_frames0", 128'(o_acq_frames), 128'(0));
        check("rst_mid_state",  128'(o_dbg_state), 128'(5'b00001));
        for (int k = 0; k < NREG; k++) model_regs[k] = '0;
        i_cmd_come = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        r_starts = 0; rises = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            if (o_acq_start) r_starts++;
            if (!o_cmd_finish) rises++;
        end
        check("post_rst_no_pulse", 128'(r_starts), 128'(0));
        check("post_rst_idle",     128'(rises), 128'(0));

        // recovery after reset
        run_cmd(16'h0001, 32'h0100_0042, -1, r_code, r_low, r_starts, r_stops, r_waits, r_done);
        model_regs[1] = 15'h0042;
        check("recov_code", 128'(r_code), 128'(16'h0000));
        check("recov_low",  128'(r_low), 128'(4));
        check("recov_regs", 128'(o_regs), 128'(flat_model()));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
